// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, tag bit positions, address slices and FSM states for the dcache controller
package dcache_pkg;
   localparam int TAG_W      = 23;
   localparam int IDX_W      = 4;
   localparam int LINE_W     = 256;
   localparam int STAG_W     = TAG_W + 2;
   localparam int V_BIT      = 24;
   localparam int D_BIT      = 23;
   localparam int TAG_LSB    = 9;
   localparam int IDX_LSB    = 5;
   localparam int WSEL_LSB   = 2;
   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_REFILL} state_e;
endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: replaces / selects one 32-bit word of a cache line
//   line_i  in  256  source line
//   word_i  in  32   word to insert
//   sel_i   in  3    word index within the line
//   line_o  out 256  line_i with word sel_i replaced by word_i
//   word_o  out 32   word sel_i of line_i
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [31:0]       word_i,
   input  logic [2:0]        sel_i,
   output logic [LINE_W-1:0] line_o,
   output logic [31:0]       word_o
);
   always_comb begin
      line_o = line_i;
      line_o[{sel_i, 5'b0} +: 32] = word_i;
   end
   assign word_o = line_i[{sel_i, 5'b0} +: 32];
endmodule

// File: rtl/dcache_wb_controller.sv
// dcache_wb_controller: write-back/write-allocate controller for a 2-way 16-set dcache
//   clk_i, rst_i                    clock, synchronous active-high reset
//   cpu_req/we/addr/data_i          CPU access; cpu_data_o load word, cpu_stall_o stalls MEM
//   sram_addr/tag/data/enable/write_o  SRAM lookup and write port
//   sram_tag/data/hit_i             SRAM lookup result (hit way, else victim way)
//   mem_addr/data/enable/write_o    memory request (level, held until mem_ack_i)
//   mem_data_i, mem_ack_i           refill line and one-cycle completion pulse
module dcache_wb_controller
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic [IDX_W-1:0]  sram_addr_o,
   output logic [STAG_W-1:0] sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   input  logic [STAG_W-1:0] sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);
   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TAG_W-1:0]   tag_q, tag_d, vtag_q, vtag_d;
   logic [LINE_W-1:0]  line_q, line_d;
   logic [TAG_W-1:0]   a_tag;
   logic [IDX_W-1:0]   a_idx;
   logic [LINE_W-1:0]  merged;
   logic [31:0]        rd_word;
   logic               unused_addr_bits;

   assign a_tag = cpu_addr_i[TAG_LSB +: TAG_W];
   assign a_idx = cpu_addr_i[IDX_LSB +: IDX_W];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   dcache_word_merge u_merge (
      .line_i (sram_data_i),
      .word_i (cpu_data_i),
      .sel_i  (cpu_addr_i[WSEL_LSB +: 3]),
      .line_o (merged),
      .word_o (rd_word)
   );

   // line_q holds the victim during WRITEBACK, then the refill line; the two never overlap
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      tag_d         = tag_q;
      vtag_d        = vtag_q;
      line_d        = line_q;
      cpu_data_o    = '0;
      cpu_stall_o   = 1'b1;
      sram_addr_o   = idx_q;
      sram_tag_o    = {2'b00, tag_q};
      sram_data_o   = '0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      case (state_q)
         S_IDLE: begin
            sram_addr_o = a_idx;
            sram_tag_o  = {2'b00, a_tag};
            cpu_stall_o = cpu_req_i & ~sram_hit_i;
            if (cpu_req_i && sram_hit_i) begin
               cpu_data_o    = rd_word;
               sram_enable_o = cpu_we_i;
               sram_write_o  = cpu_we_i;
               sram_tag_o    = cpu_we_i ? {2'b11, a_tag} : {2'b00, a_tag};
               sram_data_o   = cpu_we_i ? merged : '0;
            end else if (cpu_req_i) begin
               idx_d   = a_idx;
               tag_d   = a_tag;
               vtag_d  = sram_tag_i[TAG_W-1:0];
               line_d  = sram_data_i;
               state_d = (sram_tag_i[V_BIT] && sram_tag_i[D_BIT]) ? S_WRITEBACK : S_ALLOCATE;
            end
         end
         S_WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {vtag_q, idx_q, 5'b0};
            mem_data_o   = line_q;
            state_d      = mem_ack_i ? S_ALLOCATE : S_WRITEBACK;
         end
         S_ALLOCATE: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {tag_q, idx_q, 5'b0};
            line_d       = mem_ack_i ? mem_data_i : line_q;
            state_d      = mem_ack_i ? S_REFILL : S_ALLOCATE;
         end
         default: begin
            sram_enable_o = 1'b1;
            sram_write_o  = 1'b1;
            sram_tag_o    = {2'b10, tag_q};
            sram_data_o   = line_q;
            state_d       = S_IDLE;
         end
      endcase
      // every output is held at zero while reset is asserted
      if (rst_i) begin
         cpu_data_o    = '0;
         cpu_stall_o   = 1'b0;
         sram_addr_o   = '0;
         sram_tag_o    = '0;
         sram_data_o   = '0;
         sram_enable_o = 1'b0;
         sram_write_o  = 1'b0;
         mem_addr_o    = '0;
         mem_data_o    = '0;
         mem_enable_o  = 1'b0;
         mem_write_o   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         tag_q   <= '0;
         vtag_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tag_q   <= tag_d;
         vtag_q  <= vtag_d;
         line_q  <= line_d;
      end
   end
endmodule
